// File: rtl/tank_move_ctrl.sv
// rtl/tank_move_ctrl.sv - per-frame tank position stepper with clamp and collision revert
// Optional frame divider: define TANK_MOVE_FRAME_DIV_EN to step once every FRAME_DIV frames.
module tank_move_ctrl #(
  parameter int INIT_X    = 304,
  parameter int INIT_Y    = 416,
  parameter int SPEED     = 4,
  parameter int SCREEN_W  = 640,
  parameter int SCREEN_H  = 480,
  parameter int TANK_W    = 32,
  parameter int TANK_H    = 32,
  parameter int COLL_WAIT = 3,
  parameter int FRAME_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        key_up,
  input  logic        key_down,
  input  logic        key_left,
  input  logic        key_right,
  input  logic        collision,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic [1:0]  direction,
  output logic        moving,
  output logic        blocked
);

  typedef enum logic [1:0] {IDLE, MOVE, WAIT_COLL, REVERT} state_t;

  localparam int CW = $clog2(COLL_WAIT) + 1;
  localparam logic [10:0] SPD11  = 11'(SPEED);
  localparam logic [11:0] SPD12  = 12'(SPEED);
  localparam logic [11:0] XMAX12 = 12'(SCREEN_W - TANK_W);
  localparam logic [11:0] YMAX12 = 12'(SCREEN_H - TANK_H);
  localparam logic [10:0] XMAX11 = 11'(SCREEN_W - TANK_W);
  localparam logic [10:0] YMAX11 = 11'(SCREEN_H - TANK_H);

  state_t          state, state_nx;
  logic [10:0]     x_nx, y_nx, sx, sy, sx_nx, sy_nx;
  logic [1:0]      dir_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            step_ok;
  logic            any_key;
  logic [11:0]     x_sum, y_sum;

  assign any_key = key_up | key_down | key_left | key_right;
  // Positive steps are summed one bit wider so the clamp sees overflow past the edge
  assign x_sum   = {1'b0, topLeftX} + SPD12;
  assign y_sum   = {1'b0, topLeftY} + SPD12;

`ifdef TANK_MOVE_FRAME_DIV_EN
  localparam int FW = $clog2(FRAME_DIV) + 1;
  logic [FW-1:0] fcnt, fcnt_nx;
  assign step_ok = (fcnt == FW'(FRAME_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fcnt <= '0;
    else       fcnt <= fcnt_nx;
  end

  always_comb begin
    fcnt_nx = fcnt;
    if (state == IDLE && startOfFrame)
      fcnt_nx = step_ok ? '0 : fcnt + 1'b1;
  end
`else
  assign step_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      topLeftX  <= 11'(INIT_X);
      topLeftY  <= 11'(INIT_Y);
      direction <= 2'd0;
      sx        <= 11'(INIT_X);
      sy        <= 11'(INIT_Y);
      cnt       <= '0;
      moving    <= 1'b0;
      blocked   <= 1'b0;
    end else begin
      state     <= state_nx;
      topLeftX  <= x_nx;
      topLeftY  <= y_nx;
      direction <= dir_nx;
      sx        <= sx_nx;
      sy        <= sy_nx;
      cnt       <= cnt_nx;
      moving    <= (state_nx == MOVE) || (state_nx == WAIT_COLL);
      blocked   <= (state_nx == REVERT);
    end
  end

  always_comb begin
    state_nx = state;
    x_nx     = topLeftX;
    y_nx     = topLeftY;
    dir_nx   = direction;
    sx_nx    = sx;
    sy_nx    = sy;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (startOfFrame && any_key && step_ok) begin
          if (key_up)        dir_nx = 2'd0;
          else if (key_down) dir_nx = 2'd2;
          else if (key_left) dir_nx = 2'd3;
          else               dir_nx = 2'd1;
          sx_nx    = topLeftX;
          sy_nx    = topLeftY;
          state_nx = MOVE;
        end
      end
      MOVE: begin
        case (direction)
          2'd0:    y_nx = (topLeftY < SPD11) ? 11'd0 : topLeftY - SPD11;
          2'd2:    y_nx = (y_sum > YMAX12) ? YMAX11 : y_sum[10:0];
          2'd3:    x_nx = (topLeftX < SPD11) ? 11'd0 : topLeftX - SPD11;
          default: x_nx = (x_sum > XMAX12) ? XMAX11 : x_sum[10:0];
        endcase
        cnt_nx   = CW'(COLL_WAIT - 1);
        state_nx = WAIT_COLL;
      end
      WAIT_COLL: begin
        if (collision) begin
          x_nx     = sx;
          y_nx     = sy;
          state_nx = REVERT;
        end else if (cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tank_move_ctrl.sv
// tb/tb_tank_move_ctrl.sv - directed self-checking bench for tank_move_ctrl
module tb_tank_move_ctrl;

  logic clk = 1'b0;
  logic reset, sof, k_up, k_down, k_left, k_right, coll;
  logic [10:0] x1, y1, x2, y2;
  logic [1:0]  d1, d2;
  logic        mv1, mv2, bl1, bl2;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tank_move_ctrl u_dut (
    .clk(clk), .reset(reset), .startOfFrame(sof),
    .key_up(k_up), .key_down(k_down), .key_left(k_left), .key_right(k_right),
    .collision(coll), .topLeftX(x1), .topLeftY(y1), .direction(d1),
    .moving(mv1), .blocked(bl1)
  );

  // Second instance starts near the top-left corner to reach the clamp edges
  tank_move_ctrl #(.INIT_X(100), .INIT_Y(2)) u_dut2 (
    .clk(clk), .reset(reset), .startOfFrame(sof),
    .key_up(k_up), .key_down(k_down), .key_left(k_left), .key_right(k_right),
    .collision(coll), .topLeftX(x2), .topLeftY(y2), .direction(d2),
    .moving(mv2), .blocked(bl2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_sof;
    @(negedge clk) sof = 1'b1;
    @(negedge clk) sof = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk) reset = 1'b1;
    {k_up, k_down, k_left, k_right, coll, sof} = '0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    {k_up, k_down, k_left, k_right, coll, sof} = '0;
    cyc(2);
    reset = 1'b0;
    cyc(1);

    check("rst_x", x1, 304);
    check("rst_y", y1, 416);
    check("rst_dir", d1, 0);
    check("rst_mv", mv1, 0);
    check("rst_bl", bl1, 0);
    for (int i = 0; i < 3; i++) begin
      pulse_sof;
      check("idle_mv", mv1, 0);
      cyc(4);
      check("idle_x", x1, 304);
      check("idle_y", y1, 416);
    end

    k_right = 1'b1;
    pulse_sof;
    check("r1_lat_x", x1, 304);
    check("r1_mv", mv1, 1);
    cyc(1);
    check("r1_x", x1, 308);
    check("r1_dir", d1, 1);
    cyc(4);
    check("r1_idle", mv1, 0);
    pulse_sof;
    check("r2_lat_x", x1, 308);
    cyc(1);
    check("r2_x", x1, 312);
    check("r2_y", y1, 416);
    cyc(4);
    k_right = 1'b0;

    do_reset;
    k_up = 1'b1;
    pulse_sof;
    cyc(1);
    check("up_clamp_y", y2, 0);
    check("up_dir", d2, 0);
    cyc(4);
    pulse_sof;
    check("up_edge_mv", mv2, 1);
    cyc(1);
    check("up_edge_y", y2, 0);
    cyc(4);
    k_up = 1'b0;

    k_left = 1'b1;
    pulse_sof;
    cyc(1);
    check("lf_x", x2, 96);
    cyc(1);
    coll = 1'b1;
    check("lf_x_hold", x2, 96);
    check("lf_nobl", bl2, 0);
    cyc(1);
    coll = 1'b0;
    check("lf_rev_x", x2, 100);
    check("lf_bl", bl2, 1);
    check("lf_dir", d2, 3);
    cyc(1);
    check("lf_bl_end", bl2, 0);
    check("lf_x_end", x2, 100);
    check("lf_mv_end", mv2, 0);
    k_left = 1'b0;
    cyc(3);

    do_reset;
    k_up = 1'b1;
    k_right = 1'b1;
    pulse_sof;
    cyc(1);
    check("pr_y", y1, 412);
    check("pr_x", x1, 304);
    check("pr_dir", d1, 0);
    sof = 1'b1;
    cyc(1);
    sof = 1'b0;
    cyc(5);
    check("pr_drop_y", y1, 412);
    check("pr_drop_mv", mv1, 0);
    k_up = 1'b0;
    k_right = 1'b0;

    do_reset;
    k_right = 1'b1;
    pulse_sof;
    cyc(1);
    check("mr_x", x1, 308);
    reset = 1'b1;
    #1;
    check("mr_x_rst", x1, 304);
    check("mr_y_rst", y1, 416);
    check("mr_mv_rst", mv1, 0);
    k_right = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);

    k_down = 1'b1;
`ifdef TANK_MOVE_FRAME_DIV_EN
    for (int f = 1; f <= 4; f++) begin
      pulse_sof;
      cyc(4);
      check("div_y", y1, (f < 2) ? 416 : (f < 4) ? 420 : 424);
    end
`else
    for (int f = 1; f <= 2; f++) begin
      pulse_sof;
      cyc(4);
      check("dn_y", y1, 416 + 4 * f);
      check("dn_dir", d1, 2);
    end
`endif
    k_down = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tank_move_ctrl.md
Name: tank_move_ctrl

Overview:
- Per-frame tank position generator; produces the tank top-left coordinates consumed by the collision checker (game_controller) and the tank drawer.
- On each frame-start pulse it samples direction keys, steps the tank by SPEED pixels and clamps it to the screen.
- It then watches the checker's registered collision flag for a fixed window. If collision is asserted in that window, it restores the pre-move position.

Parameters:
- INIT_X, 304, tank top-left X after reset
- INIT_Y, 416, tank top-left Y after reset
- SPEED, 4, pixels moved per accepted step (1..31)
- SCREEN_W, 640, screen width in pixels
- SCREEN_H, 480, screen height in pixels
- TANK_W, 32, tank width
- TANK_H, 32, tank height
- COLL_WAIT, 3, cycles the collision flag is watched after a move (>=2; checker latency is 1 cycle after position change)
- FRAME_DIV, 2, frames per step when the optional feature is enabled (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- startOfFrame  in  1  single-cycle pulse, once per video frame
- key_up  in  1  level, move up request
- key_down  in  1  level, move down request
- key_left  in  1  level, move left request
- key_right  in  1  level, move right request
- collision  in  1  registered tank/brick collision flag from checker
- topLeftX  out  11  tank top-left X
- topLeftY  out  11  tank top-left Y
- direction  out  2  facing: 0 up, 1 right, 2 down, 3 left
- moving  out  1  high while state is MOVE or WAIT_COLL
- blocked  out  1  single-cycle pulse when a move is reverted

Behaviour:
- Reset (async, active-high):
  - topLeftX=INIT_X, topLeftY=INIT_Y, direction=0.
  - moving=0, blocked=0, state=IDLE.
  - Wait counter=0, saved position=INIT.
- All outputs are registered; all updates occur on rising clk.
- States: IDLE, MOVE, WAIT_COLL, REVERT.
- IDLE:
  - On startOfFrame with at least one key high: latch direction by priority up > down > left > right, save current X/Y, go to MOVE.
  - On startOfFrame with no key high: stay in IDLE, no change.
  - The collision input is ignored in IDLE.
- MOVE (1 cycle): apply the step, then go to WAIT_COLL with counter=COLL_WAIT-1.
  - Up: Y = (Y < SPEED) ? 0 : Y-SPEED.
  - Down: Y = min(Y+SPEED, SCREEN_H-TANK_H).
  - Left: X = (X < SPEED) ? 0 : X-SPEED.
  - Right: X = min(X+SPEED, SCREEN_W-TANK_W).
  - Arithmetic is done 12 bits wide, then clamped; no wrap-around is permitted.
  - Direction is updated even if the clamped position is unchanged.
- WAIT_COLL:
  - Counter decrements each cycle.
  - If collision=1 in any cycle of the window: go to REVERT immediately.
  - If the counter reaches 0 with no collision: go to IDLE, keeping the new position.
- REVERT (1 cycle): X/Y restored to saved values, blocked=1 for this cycle only, direction kept, then go to IDLE.
- Key-to-position latency: position changes on the 2nd rising edge after the startOfFrame cycle.
- startOfFrame arriving while not in IDLE is dropped (no queuing).
- Keys changing during MOVE/WAIT_COLL have no effect.
- Multiple keys pressed: priority rule above; only one axis moves.
- Reset asserted mid-operation returns everything to reset values at once; the saved position is discarded.
- A tank already at a clamp boundary that keeps pressing toward it: position is unchanged, still passes through MOVE and WAIT_COLL, and blocked can still fire if a collision is present.

Optional Feature:
- Macro: TANK_MOVE_FRAME_DIV_EN.
- Defined: a frame counter (width clog2(FRAME_DIV)+1) increments on every startOfFrame seen in IDLE.
  - A step is taken only when the counter equals FRAME_DIV-1; the counter then returns to 0.
  - Frames with no key pressed still advance the counter.
  - Reset clears the counter.
- Not defined: a step is attempted on every startOfFrame accepted in IDLE; no counter logic exists.

Test Plan:
- Reset release, no keys, 3 frames -> topLeftX=304, topLeftY=416, direction=0, moving=0 throughout.
- key_right held, 2 frames, no collision -> X 304→308→312; each update 2 cycles after startOfFrame; direction=1.
- key_up held from Y=2 with SPEED=4 -> Y=0 (clamped, no wrap); next frame Y stays 0.
- key_left at X=100; collision=1 on 2nd cycle of WAIT_COLL -> X goes to 96 then back to 100; blocked pulses 1 cycle; direction=3.
- key_up and key_right held together -> only Y decreases by 4; direction=0. Extra startOfFrame during WAIT_COLL -> ignored, single step only.
- reset asserted during WAIT_COLL after X moved to 308 -> X=304, Y=416 immediately. With TANK_MOVE_FRAME_DIV_EN and FRAME_DIV=2, key_down held 4 frames -> Y changes only on frames 2 and 4 (420, 424).
